// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: two-entry skid pipeline stage with flush (ctrl kill, payload kept), freeze and saturating drop count
module pipe_stage_skid #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  freeze,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;
  logic [1:0]            state_q, state_d;
  logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_WIDTH:0]    drop_sum;
  logic                  main_valid, in_fire, out_fire;
  // Valid bits are implied by the state encoding, so they can never disagree with it.
  assign main_valid = state_q != EMPTY;
  assign in_ready   = rst && state_q != TWO && !freeze;
  assign out_valid  = main_valid;
  assign out_ctrl   = main_valid ? main_ctrl_q : '0;
  assign out_data   = main_data_q;
  assign occupancy  = state_q;
  assign drop_cnt   = drop_cnt_q;
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = main_valid && out_ready && !freeze;
  assign drop_sum   = {1'b0, drop_cnt_q} + {{(CNT_WIDTH-1){1'b0}}, state_q};
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    drop_cnt_d  = drop_cnt_q;
    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      drop_cnt_d  = drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
    end else if (state_q == TWO) begin
      if (out_fire) begin
        state_d     = ONE;
        main_ctrl_d = skid_ctrl_q;
        main_data_d = skid_data_q;
        skid_ctrl_d = '0;
      end
    end else if (in_fire && (state_q == EMPTY || out_fire)) begin
      state_d     = ONE;
      main_ctrl_d = in_ctrl;
      main_data_d = in_data;
    end else if (in_fire) begin
      state_d     = TWO;
      skid_ctrl_d = in_ctrl;
      skid_data_d = in_data;
    end else if (out_fire) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed and randomized checks of pipe_stage_skid against a queue-based reference model
module tb_pipe_stage_skid;
  localparam int DW = 32;
  localparam int CW = 8;
  localparam int NW = 5;
  localparam int DROP_MAX = (1 << NW) - 1;
  logic          clk = 0, rst = 0, flush = 0, freeze = 0, in_valid = 0, out_ready = 0;
  logic [CW-1:0] in_ctrl = 0, out_ctrl;
  logic [DW-1:0] in_data = 0, out_data;
  logic          in_ready, out_valid;
  logic [1:0]    occupancy;
  logic [NW-1:0] drop_cnt;
  typedef struct { logic [CW-1:0] c; logic [DW-1:0] d; } ent_t;
  ent_t q[$];
  int drops = 0, checks = 0, errors = 0;
  pipe_stage_skid #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(logic v, logic [CW-1:0] c, logic [DW-1:0] d, logic ordy, logic frz, logic fl);
    in_valid = v; in_ctrl = c; in_data = d; out_ready = ordy; freeze = frz; flush = fl;
  endtask
  // Called at a falling edge with inputs already driven; checks outputs, then advances one clock.
  task automatic cycle();
    bit ifire, ofire;
    #1;
    chk("out_valid", out_valid, q.size() != 0);
    chk("occupancy", occupancy, q.size());
    chk("in_ready", in_ready, q.size() < 2 && !freeze);
    chk("out_ctrl", out_ctrl, q.size() != 0 ? q[0].c : 0);
    if (q.size() != 0) chk("out_data", out_data, q[0].d);
    chk("drop_cnt", drop_cnt, drops);
    ifire = in_valid && q.size() < 2 && !freeze;
    ofire = q.size() != 0 && out_ready && !freeze;
    @(posedge clk);
    if (flush) begin
      drops = (drops + q.size() > DROP_MAX) ? DROP_MAX : drops + q.size();
      q.delete();
    end else begin
      if (ofire) void'(q.pop_front());
      if (ifire) q.push_back('{c: in_ctrl, d: in_data});
    end
    @(negedge clk);
  endtask
  initial begin
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    @(negedge clk);
    rst = 1;
    for (int i = 1; i <= 8; i++) begin
      drive(1, CW'(i + 8'h10), DW'(i), 1, 0, 0);
      cycle();
    end
    drive(0, 0, 0, 1, 0, 0);
    cycle();
    drive(1, 8'hAA, 32'hA, 0, 0, 0); cycle();
    drive(1, 8'hBB, 32'hB, 0, 0, 0); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'hCC, 32'hC, 0, 0, 0); cycle();
    end
    for (int i = 0; i < 4; i++) begin
      drive(i == 0, 8'hCC, 32'hC, 1, 0, 0); cycle();
    end
    drive(1, 8'h11, 32'h1, 0, 0, 0); cycle();
    drive(1, 8'h22, 32'h2, 0, 0, 0); cycle();
    drive(1, 8'h33, 32'h3, 1, 1, 1); cycle();
    drive(0, 0, 0, 1, 0, 0); cycle();
    drive(1, 8'h44, 32'h44, 0, 0, 0); cycle();
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'h55, 32'h55, 1, 1, 0); cycle();
    end
    drive(0, 0, 0, 1, 0, 0); cycle();
    cycle();
    for (int i = 0; i < 20; i++) begin
      drive(1, 8'h60, DW'(i), 0, 0, 0); cycle();
      drive(1, 8'h61, DW'(i), 0, 0, 0); cycle();
      drive(0, 0, 0, 0, 0, 1); cycle();
    end
    repeat (400) begin
      drive($urandom_range(0, 3) != 0, CW'($urandom), $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
      cycle();
    end
    drive(1, 8'h71, 32'h71, 0, 0, 0); cycle();
    drive(1, 8'h72, 32'h72, 0, 0, 0); cycle();
    #2 rst = 0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_ctrl", out_ctrl, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_occupancy", occupancy, 0);
    chk("arst_drop_cnt", drop_cnt, 0);
    q.delete();
    drops = 0;
    @(negedge clk);
    rst = 1;
    repeat (200) begin
      drive($urandom_range(0, 3) != 0, CW'($urandom), $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, payload bits held through flush.
REQ-002 Parameter: CTRL_WIDTH, default 8, control bits (mem/wb/status/branch enables) zeroed on flush.
REQ-003 Parameter: CNT_WIDTH, default 16, width of flush-drop counter.
REQ-004 Port: clk  in  1  sole clock, rising edge.
REQ-005 Port: rst  in  1  reset; asynchronous and active-low (0 = reset).
REQ-006 Port: flush  in  1  kill all held entries.
REQ-007 Port: freeze  in  1  hazard stall; blocks all transfers.
REQ-008 Port: in_valid  in  1  upstream entry present.
REQ-009 Port: in_ready  out  1  stage can accept.
REQ-010 Port: in_ctrl  in  CTRL_WIDTH  upstream control bits.
REQ-011 Port: in_data  in  DATA_WIDTH  upstream payload.
REQ-012 Port: out_valid  out  1  entry presented downstream.
REQ-013 Port: out_ready  in  1  downstream accepts.
REQ-014 Port: out_ctrl  out  CTRL_WIDTH  control of head entry.
REQ-015 Port: out_data  out  DATA_WIDTH  payload of head entry.
REQ-016 Port: occupancy  out  2  entries held, 0..2.
REQ-017 Port: drop_cnt  out  CNT_WIDTH  valid entries discarded by flush, saturating.

Function
REQ-018 Storage SHALL be two entries: main (drives out_*) and skid; each holds valid, ctrl, data.
REQ-019 States SHALL be EMPTY (none valid), ONE (main only), TWO (main+skid); occupancy = 0/1/2 respectively.
REQ-020 in_ready SHALL be a registered-state function: 1 iff state != TWO and freeze = 0.
REQ-021 out_valid SHALL equal main valid, independent of freeze.
REQ-022 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready & ~freeze.
REQ-023 EMPTY: in_fire -> ONE, entry written to main; else stay.
REQ-024 ONE: in_fire & out_fire -> ONE, main replaced by input; in_fire only -> TWO, input to skid; out_fire only -> EMPTY; neither -> stay.
REQ-025 TWO: out_fire -> ONE, skid moves to main, skid invalidated; else stay (no input accepted).
REQ-026 Latency SHALL be one cycle: data accepted at edge N appears on out_* after edge N when stage was empty.
REQ-027 Ordering SHALL be strict FIFO; no entry lost or duplicated absent flush.
REQ-028 freeze=1 (flush=0): all storage, state and counter hold; out_* stable.
REQ-029 flush=1 SHALL dominate freeze and in_valid: next edge -> EMPTY, both valid bits and both ctrl fields cleared to 0, data fields retain value, input in that cycle discarded.
REQ-030 On flush, drop_cnt SHALL add occupancy (0,1,2), saturating at all-ones; incoming in_valid not counted.
REQ-031 out_ctrl SHALL read 0 whenever out_valid = 0.
REQ-032 drop_cnt SHALL never wrap; at max it holds.

Reset
REQ-033 rst=0 SHALL immediately (asynchronously) force state EMPTY, all valid/ctrl/data to 0, drop_cnt to 0.
REQ-034 During reset: out_valid=0, in_ready=0, occupancy=0; in_ready rises the first cycle after rst=1 with freeze=0.
REQ-035 Reset asserted mid-transfer SHALL discard all entries without counting drops.

Verification
REQ-036 Stream: in_valid=1 for data 1..8, out_ready=1 -> out_data 1..8 in order, one per cycle, occupancy stays 1, in_ready held 1.
REQ-037 Backpressure: out_ready=0, push A,B -> occupancy 2, in_ready=0, C held upstream; out_ready=1 -> A, B, C out in order.
REQ-038 Flush with occupancy 2 and in_valid=1, freeze=1 -> next cycle EMPTY, out_valid=0, out_ctrl=0, drop_cnt=2.
REQ-039 freeze=1 for 5 cycles with occupancy 1, out_ready=1 -> out_data unchanged, no pop, in_ready=0; release -> pop next edge.
REQ-040 drop_cnt at 16'hFFFF, flush with occupancy 2 -> stays 16'hFFFF.
REQ-041 rst=0 asserted between clock edges with occupancy 2 -> outputs zero before next edge; drop_cnt=0.
